// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - wide add sequenced nibble-by-nibble through an external 4-bit CLA slice
// Optional subtract mode: define CLA_SEQ_SUB_EN to add the req_sub port.
module cla_word_sequencer #(
    parameter int WORDS     = 4,
    parameter int SLICE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4*WORDS-1:0] req_a,
    input  logic [4*WORDS-1:0] req_b,
    input  logic               req_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic               req_sub,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [4*WORDS-1:0] rsp_sum,
    output logic               rsp_cout,
    output logic [3:0]         slc_a,
    output logic [3:0]         slc_b,
    output logic               slc_cin,
    output logic               slc_valid,
    input  logic [3:0]         slc_sum,
    input  logic               slc_cout,
    output logic               busy
);
    localparam int W  = 4 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = (SLICE_LAT > 1) ? $clog2(SLICE_LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(SLICE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   wait_cnt;
    logic            carry;
    logic [IW+1:0]   nib_lsb;
    logic [W-1:0]    b_in;
    logic            cin_in;

    // Subtraction is A + ~B + 1, so the inversion is folded into the latched B.
`ifdef CLA_SEQ_SUB_EN
    assign b_in   = req_sub ? ~req_b : req_b;
    assign cin_in = req_sub ? 1'b1 : req_cin;
`else
    assign b_in   = req_b;
    assign cin_in = req_cin;
`endif

    assign nib_lsb   = {idx, 2'b00};
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_DONE);

    // Slice inputs decode straight from registers that only move at nibble boundaries,
    // so they hold steady through ISSUE and all of WAIT.
    assign slc_a     = a_reg[nib_lsb +: 4];
    assign slc_b     = b_reg[nib_lsb +: 4];
    assign slc_cin   = carry;
    assign slc_valid = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            carry    <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_reg <= req_a;
                        b_reg <= b_in;
                        carry <= cin_in;
                        idx   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        rsp_sum[nib_lsb +: 4] <= slc_sum;
                        carry                 <= slc_cout;
                        if (idx == LAST_IDX) begin
                            rsp_cout <= slc_cout;
                            state    <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb/tb_cla_word_sequencer.sv - scoreboard bench for cla_word_sequencer with a behavioural CLA slice
module tb_cla_word_sequencer;
    localparam int WORDS = 4;
    localparam int SL    = 2;
    localparam int W     = 4 * WORDS;
    localparam int LAT   = WORDS * (SL + 1);

    typedef struct {
        logic [W-1:0]     sum;
        logic             cout;
        logic [WORDS-1:0] cins;
    } exp_t;

    logic clk = 1'b0;
    logic rst, req_valid, req_ready, req_cin, req_sub;
    logic [W-1:0] req_a, req_b, rsp_sum;
    logic rsp_valid, rsp_ready, rsp_cout, busy;
    logic [3:0] slc_a, slc_b, slc_sum;
    logic slc_cin, slc_valid, slc_cout;

    always #5 clk = ~clk;

    cla_word_sequencer #(.WORDS(WORDS), .SLICE_LAT(SL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef CLA_SEQ_SUB_EN
        .req_sub(req_sub),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin), .slc_valid(slc_valid),
        .slc_sum(slc_sum), .slc_cout(slc_cout),
        .busy(busy)
    );

    // Slice: adds its inputs and presents the result SL clocks later.
    logic [4:0] pipe [SL];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, slc_a} + {1'b0, slc_b} + {4'b0, slc_cin};
        for (int i = 1; i < SL; i++) pipe[i] <= pipe[i-1];
    end
    assign slc_sum  = pipe[SL-1][3:0];
    assign slc_cout = pipe[SL-1][4];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    bit   rand_rdy = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t   e;
        longint s, m;
        s      = longint'(a) + longint'(b) + longint'(cin);
        e.sum  = W'(s % (longint'(1) << W));
        e.cout = (s >= (longint'(1) << W));
        for (int i = 0; i < WORDS; i++) begin
            m         = longint'(1) << (4 * i);
            e.cins[i] = ((longint'(a) % m) + (longint'(b) % m) + longint'(cin)) >= m;
        end
        return e;
    endfunction

    function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub);
        if (sub) return model(a, ~b, 1'b1);
        return model(a, b, cin);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency, slice pulse count, per-nibble carries, and result at handshake.
    int               pulses = 0;
    logic [WORDS-1:0] cin_seen = '0;
    logic             rsp_valid_d = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            acc_q.delete();
            pulses      = 0;
            cin_seen    = '0;
            rsp_valid_d = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc + 1);
                pulses   = 0;
                cin_seen = '0;
            end
            if (slc_valid) begin
                if (pulses < WORDS) cin_seen[pulses] = slc_cin;
                pulses++;
            end
            if (rsp_valid && !rsp_valid_d) begin
                if (acc_q.size() == 0) chk("rsp_without_accept", 1, 0);
                else chk("latency", cyc - acc_q.pop_front(), LAT);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_cout", rsp_cout, e.cout);
                    chk("slc_pulses", pulses, WORDS);
                    chk("slc_cin_seq", cin_seen, e.cins);
                end
            end
            rsp_valid_d = rsp_valid;
        end
    end

    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        int n    = 0;
        bit took = 0;
        exp_q.push_back(model_op(a, b, cin, sub));
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        while (!took && n < 200) begin
            took = req_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!took) chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
        req_a = W'($urandom); req_b = W'($urandom); req_cin = 1'($urandom);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) chk("rsp_timeout", 0, 1);
        rsp_ready = 1'b1;
    endtask

    initial begin
        exp_t e1;
        int   n0;
        rst = 1'b1; req_valid = 0; req_a = 0; req_b = 0; req_cin = 0; req_sub = 0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_slc_valid", slc_valid, 0);
        chk("rst_slc_ab", {slc_a, slc_b, slc_cin}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(16'h1234, 16'h4321, 0, 0); wait_rsp();
        do_req(16'h0FFF, 16'h0001, 0, 0); wait_rsp();
        do_req(16'hFFFF, 16'h0001, 0, 0); wait_rsp();
        do_req(16'hFFFF, 16'h0000, 1, 0); wait_rsp();

        // Back-pressure in DONE with a competing request held on the input.
        rsp_ready = 1'b0;
        e1 = model(16'h00A5, 16'h0F0F, 1'b0);
        do_req(16'h00A5, 16'h0F0F, 0, 0);
        n0 = 0;
        while (!rsp_valid && n0 < 100) begin @(posedge clk); #1; n0++; end
        chk("hold_reach_done", rsp_valid, 1);
        exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
        req_a = 16'h1111; req_b = 16'h2222; req_cin = 0; req_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_sum", rsp_sum, e1.sum);
            chk("hold_cout", rsp_cout, e1.cout);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_rsp_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", req_ready, 1);
        chk("release_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("release_accept", busy, 1);
        req_valid = 1'b0;
        wait_rsp();

        // Reset during the WAIT of nibble 2.
        do_req(16'h1111, 16'h2222, 0, 0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("abort_req_ready", req_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp", {rsp_sum, rsp_cout}, 0);
        chk("abort_slc", {slc_valid, slc_a, slc_b, slc_cin}, 0);
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid) chk("abort_no_rsp", rsp_valid, 0);
        end
        do_req(16'h0003, 16'h0002, 0, 0); wait_rsp();

`ifdef CLA_SEQ_SUB_EN
        do_req(16'h0007, 16'h0002, 0, 1); wait_rsp();
        do_req(16'h0002, 16'h0003, 1, 1); wait_rsp();
`endif

        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
`ifdef CLA_SEQ_SUB_EN
            do_req(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
            do_req(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
            wait_rsp();
        end
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
